// File: rtl/legv8_pkg.sv
// Shared LEGv8 encoding definitions: request kinds, opcode constants and
// field-packing helpers used by the program encoder (and by maindec).
package legv8_pkg;

    typedef enum logic [2:0] {
        KIND_ADD     = 3'd0,
        KIND_SUB     = 3'd1,
        KIND_AND     = 3'd2,
        KIND_ORR     = 3'd3,
        KIND_LDUR    = 3'd4,
        KIND_STUR    = 3'd5,
        KIND_CBZ     = 3'd6,
        KIND_ILLEGAL = 3'd7
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } enc_state_e;

    localparam logic [10:0] OPC_ADD  = 11'h458;
    localparam logic [10:0] OPC_SUB  = 11'h658;
    localparam logic [10:0] OPC_AND  = 11'h450;
    localparam logic [10:0] OPC_ORR  = 11'h550;
    localparam logic [10:0] OPC_LDUR = 11'h7C2;
    localparam logic [10:0] OPC_STUR = 11'h7C0;
    localparam logic [7:0]  OPC_CBZ  = 8'hB4;

    // R-format: opcode | Rm | shamt(0) | Rn | Rd
    function automatic logic [31:0] enc_r(input logic [10:0] opc,
                                          input logic [4:0]  rm,
                                          input logic [4:0]  rn,
                                          input logic [4:0]  rd);
        return {opc, rm, 6'b000000, rn, rd};
    endfunction

    // D-format: opcode | DT_address | op2(00) | Rn | Rt
    function automatic logic [31:0] enc_d(input logic [10:0] opc,
                                          input logic [8:0]  dt_addr,
                                          input logic [4:0]  rn,
                                          input logic [4:0]  rt);
        return {opc, dt_addr, 2'b00, rn, rt};
    endfunction

    // CB-format: opcode | CondBrAddr | Rt
    function automatic logic [31:0] enc_cb(input logic [7:0]  opc,
                                           input logic [18:0] br_addr,
                                           input logic [4:0]  rt);
        return {opc, br_addr, rt};
    endfunction

endpackage

// File: rtl/legv8_instr_pack.sv
// Combinational packer: symbolic request kind plus register/immediate fields
// into a 32-bit LEGv8 machine word, with a legality flag for kind 7.
module legv8_instr_pack
    import legv8_pkg::*;
(
    input  kind_e        i_kind,
    input  logic [4:0]   i_rd,
    input  logic [4:0]   i_rn,
    input  logic [4:0]   i_rm,
    input  logic [18:0]  i_imm,
    output logic         o_legal,
    output logic [31:0]  o_word
);

    logic [8:0] w_dt_addr;

    // D-format only carries the low 9 immediate bits; upper bits are dropped.
    assign w_dt_addr = i_imm[8:0];

    always_comb begin
        o_legal = 1'b1;
        o_word  = '0;
        case (i_kind)
            KIND_ADD:  o_word = enc_r(OPC_ADD, i_rm, i_rn, i_rd);
            KIND_SUB:  o_word = enc_r(OPC_SUB, i_rm, i_rn, i_rd);
            KIND_AND:  o_word = enc_r(OPC_AND, i_rm, i_rn, i_rd);
            KIND_ORR:  o_word = enc_r(OPC_ORR, i_rm, i_rn, i_rd);
            KIND_LDUR: o_word = enc_d(OPC_LDUR, w_dt_addr, i_rn, i_rd);
            KIND_STUR: o_word = enc_d(OPC_STUR, w_dt_addr, i_rn, i_rd);
            KIND_CBZ:  o_word = enc_cb(OPC_CBZ, i_imm, i_rd);
            default:   o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/legv8_prog_encoder.sv
// Program loader: accepts symbolic LEGv8 requests, encodes them and streams
// the words into consecutive instruction-memory addresses until imem is full.
module legv8_prog_encoder
    import legv8_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_kind,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rn,
    input  logic [4:0]    in_rm,
    input  logic [18:0]   in_imm,
    output logic          imem_we,
    output logic [AW-1:0] imem_waddr,
    output logic [31:0]   imem_wdata,
    output logic          done,
    output logic [7:0]    err_cnt
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    enc_state_e    r_state;
    enc_state_e    w_state_next;
    logic          w_in_ready;
    logic          w_accept;
    logic          w_legal;
    logic [31:0]   w_word;
    logic [AW-1:0] r_addr;
    logic          r_we;
    logic [AW-1:0] r_waddr;
    logic [31:0]   r_wdata;
    logic [7:0]    r_err_cnt;

    legv8_instr_pack u_pack (
        .i_kind  (kind_e'(in_kind)),
        .i_rd    (in_rd),
        .i_rn    (in_rn),
        .i_rm    (in_rm),
        .i_imm   (in_imm),
        .o_legal (w_legal),
        .o_word  (w_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // start overrides everything and blocks acceptance in its own cycle.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        if (start) begin
            w_state_next = ST_LOAD;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    w_in_ready = 1'b1;
                    if (in_valid && w_legal && (r_addr == LAST_ADDR)) begin
                        w_state_next = ST_FULL;
                    end
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    assign w_accept = in_valid & w_in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_err_cnt <= '0;
        end else begin
            r_we <= 1'b0;
            if (start) begin
                r_addr    <= '0;
                r_err_cnt <= '0;
            end else if (w_accept) begin
                if (w_legal) begin
                    r_we    <= 1'b1;
                    r_waddr <= r_addr;
                    r_wdata <= w_word;
                    // Natural AW-bit wrap returns the counter to 0 as FULL is entered.
                    r_addr  <= r_addr + AW'(1);
                end else if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign imem_we    = r_we;
    assign imem_waddr = r_waddr;
    assign imem_wdata = r_wdata;
    assign done       = (r_state == ST_FULL);
    assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_legv8_prog_encoder.sv
// Self-checking bench for legv8_prog_encoder: vector table, directed corner
// sequences and randomized traffic against a word-count reference model.
module tb_legv8_prog_encoder;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_kind;
    logic [4:0]  in_rd;
    logic [4:0]  in_rn;
    logic [4:0]  in_rm;
    logic [18:0] in_imm;
    logic        imem_we;
    logic [5:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        done;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: words written since start, whether a load is active.
    bit          m_active;
    int          m_loaded;
    int          m_err;
    bit          m_we;
    int          m_waddr;
    logic [31:0] m_wdata;

    always #5 clk = ~clk;

    legv8_prog_encoder #(.DEPTH(DEPTH), .AW(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_rd      (in_rd),
        .in_rn      (in_rn),
        .in_rm      (in_rm),
        .in_imm     (in_imm),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .done       (done),
        .err_cnt    (err_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic form of the instruction formats.
    function automatic logic [31:0] ref_word(input logic [2:0] kind, input logic [4:0] rd,
                                             input logic [4:0] rn, input logic [4:0] rm,
                                             input logic [18:0] imm);
        longint unsigned w;
        longint unsigned opc;
        w = 0;
        case (kind)
            3'd0, 3'd1, 3'd2, 3'd3: begin
                opc = (kind == 3'd0) ? 'h458 : (kind == 3'd1) ? 'h658 :
                      (kind == 3'd2) ? 'h450 : 'h550;
                w = opc * (2**21) + longint'(rm) * 65536 + longint'(rn) * 32 + longint'(rd);
            end
            3'd4, 3'd5: begin
                opc = (kind == 3'd4) ? 'h7C2 : 'h7C0;
                w = opc * (2**21) + (longint'(imm) % 512) * 4096 + longint'(rn) * 32 + longint'(rd);
            end
            3'd6: w = 'hB4 * (2**24) + longint'(imm) * 32 + longint'(rd);
            default: w = 0;
        endcase
        return w[31:0];
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_loaded = 0;
        m_err    = 0;
        m_we     = 0;
        m_waddr  = 0;
        m_wdata  = '0;
    endtask

    // One clock: drive at posedge+1, check at negedge, advance model at posedge.
    task automatic cycle(input bit st, input bit v, input logic [2:0] kind,
                         input logic [4:0] rd, input logic [4:0] rn,
                         input logic [4:0] rm, input logic [18:0] imm);
        bit rdy;
        start    = st;
        in_valid = v;
        in_kind  = kind;
        in_rd    = rd;
        in_rn    = rn;
        in_rm    = rm;
        in_imm   = imm;
        @(negedge clk);
        rdy = m_active && (m_loaded < DEPTH) && !st;
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("imem_we", 32'(imem_we), 32'(m_we));
        chk("imem_waddr", 32'(imem_waddr), 32'(m_waddr));
        chk("imem_wdata", imem_wdata, m_wdata);
        chk("done", 32'(done), 32'(m_active && (m_loaded == DEPTH)));
        chk("err_cnt", 32'(err_cnt), 32'(m_err));
        m_we = 0;
        if (st) begin
            m_active = 1;
            m_loaded = 0;
            m_err    = 0;
        end else if (v && rdy) begin
            if (kind != 3'd7) begin
                m_we     = 1;
                m_waddr  = m_loaded;
                m_wdata  = ref_word(kind, rd, rn, rm, imm);
                m_loaded = m_loaded + 1;
            end else if (m_err < 255) begin
                m_err = m_err + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
    endtask

    typedef struct {
        logic [2:0]  kind;
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [18:0] imm;
        bit          legal;
        logic [31:0] word;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{3'd0, 5'd1,  5'd2,  5'd3,  19'd0,      1, 32'h8B030041};
        vecs[1] = '{3'd4, 5'd1,  5'd2,  5'd9,  19'd8,      1, 32'hF8408041};
        vecs[2] = '{3'd5, 5'd3,  5'd0,  5'd0,  19'd0,      1, 32'hF8000003};
        vecs[3] = '{3'd6, 5'd5,  5'd7,  5'd4,  19'd4,      1, 32'hB4000085};
        vecs[4] = '{3'd1, 5'd31, 5'd30, 5'd29, 19'd0,      1, 32'hCB1D03DF};
        vecs[5] = '{3'd2, 5'd0,  5'd0,  5'd0,  19'h7FFFF,  1, 32'h8A000000};
        vecs[6] = '{3'd3, 5'd7,  5'd8,  5'd9,  19'd0,      1, 32'hAA090107};
        vecs[7] = '{3'd4, 5'd2,  5'd3,  5'd31, 19'h7FFFF,  1, 32'hF85FF062};
        vecs[8] = '{3'd6, 5'd0,  5'd0,  5'd0,  19'h7FFFF,  1, 32'hB4FFFFE0};
        vecs[9] = '{3'd7, 5'd1,  5'd1,  5'd1,  19'd1,      0, 32'h0};

        start = 0; in_valid = 0; in_kind = '0; in_rd = '0; in_rn = '0; in_rm = '0; in_imm = '0;
        reset = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 0;
        idle();
        // IDLE does not accept requests
        cycle(0, 1, 3'd0, 5'd1, 5'd2, 5'd3, 19'd0);

        // Vector table, one start per vector so every legal word lands at 0.
        for (int i = 0; i < 10; i++) begin
            cycle(1, 0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
            cycle(0, 1, vecs[i].kind, vecs[i].rd, vecs[i].rn, vecs[i].rm, vecs[i].imm);
            chk($sformatf("tbl%0d_we", i), 32'(imem_we), 32'(vecs[i].legal));
            if (vecs[i].legal) begin
                chk($sformatf("tbl%0d_wdata", i), imem_wdata, vecs[i].word);
                chk($sformatf("tbl%0d_waddr", i), 32'(imem_waddr), 32'd0);
            end else begin
                chk($sformatf("tbl%0d_err", i), 32'(err_cnt), 32'd1);
            end
            idle();
        end

        // Back-to-back LDUR/STUR/CBZ
        cycle(1, 0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
        cycle(0, 1, 3'd4, 5'd1, 5'd2, 5'd0, 19'd8);
        chk("b2b0", {26'd0, imem_waddr} ^ imem_wdata, 32'hF8408041);
        cycle(0, 1, 3'd5, 5'd3, 5'd0, 5'd0, 19'd0);
        chk("b2b1", imem_wdata, 32'hF8000003);
        chk("b2b1_addr", 32'(imem_waddr), 32'd1);
        cycle(0, 1, 3'd6, 5'd5, 5'd0, 5'd0, 19'd4);
        chk("b2b2", imem_wdata, 32'hB4000085);
        chk("b2b2_addr", 32'(imem_waddr), 32'd2);
        idle();

        // Illegal between two ADDs
        cycle(1, 0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
        cycle(0, 1, 3'd0, 5'd1, 5'd2, 5'd3, 19'd0);
        cycle(0, 1, 3'd7, 5'd1, 5'd2, 5'd3, 19'd0);
        chk("ill_no_we", 32'(imem_we), 32'd0);
        cycle(0, 1, 3'd0, 5'd4, 5'd5, 5'd6, 19'd0);
        chk("ill_addr1", 32'(imem_waddr), 32'd1);
        chk("ill_err1", 32'(err_cnt), 32'd1);
        idle();

        // Request coincident with a mid-LOAD start is dropped
        cycle(1, 1, 3'd0, 5'd9, 5'd9, 5'd9, 19'd0);
        chk("st_drop", 32'(imem_we), 32'd0);

        // Fill to DEPTH, then overflow attempts
        cycle(1, 0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
        for (int i = 0; i < DEPTH; i++)
            cycle(0, 1, 3'(i % 7), 5'(i), 5'(i + 1), 5'(i + 2), 19'(i * 3));
        chk("full_last_addr", 32'(imem_waddr), 32'(DEPTH - 1));
        chk("full_done", 32'(done), 32'd1);
        chk("full_ready", 32'(in_ready), 32'd0);
        repeat (3) cycle(0, 1, 3'd0, 5'd1, 5'd1, 5'd1, 19'd0);

        // Restart from FULL
        cycle(1, 0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
        chk("restart_done", 32'(done), 32'd0);
        cycle(0, 1, 3'd1, 5'd2, 5'd3, 5'd4, 19'd0);
        chk("restart_addr", 32'(imem_waddr), 32'd0);
        chk("restart_we", 32'(imem_we), 32'd1);

        // err_cnt saturation
        for (int i = 0; i < 260; i++)
            cycle(0, 1, 3'd7, 5'd0, 5'd0, 5'd0, 19'd0);
        chk("err_sat", 32'(err_cnt), 32'd255);

        // Reset with a write pending on the outputs
        cycle(0, 1, 3'd0, 5'd1, 5'd2, 5'd3, 19'd0);
        chk("pre_rst_we", 32'(imem_we), 32'd1);
        chk("pre_rst_opc", 32'(imem_wdata[31:21]), 32'h458);
        reset = 1;
        #1;
        chk("arst_we", 32'(imem_we), 32'd0);
        chk("arst_waddr", 32'(imem_waddr), 32'd0);
        chk("arst_wdata", imem_wdata, 32'd0);
        chk("arst_err", 32'(err_cnt), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 0;
        idle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit st;
            bit v;
            logic [2:0] k;
            st = ($urandom_range(0, 99) == 0);
            v  = ($urandom_range(0, 9) < 7);
            k  = 3'($urandom_range(0, 7));
            cycle(st, v, k, 5'($urandom), 5'($urandom), 5'($urandom), 19'($urandom));
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
